// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V control unit: opcodes, FSM state
// encoding, instruction path classes and datapath select codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // What the instruction does after EXEC.
  typedef enum logic [2:0] {
    P_NONE   = 3'd0,
    P_WB     = 3'd1,
    P_LOAD   = 3'd2,
    P_STORE  = 3'd3,
    P_BRANCH = 3'd4,
    P_NOP    = 3'd5,
    P_SYS    = 3'd6
  } path_t;

  localparam logic [2:0] M2R_ALU   = 3'b000;
  localparam logic [2:0] M2R_MEM   = 3'b001;
  localparam logic [2:0] M2R_PC4   = 3'b010;
  localparam logic [2:0] M2R_IMM   = 3'b011;
  localparam logic [2:0] M2R_AUIPC = 3'b100;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_IMM = 2'b01;
  localparam logic [1:0] ALUOP_REG = 2'b10;
  localparam logic [1:0] ALUOP_BR  = 2'b11;

  localparam logic [1:0] PCM_SEQ  = 2'b00;
  localparam logic [1:0] PCM_JAL  = 2'b01;
  localparam logic [1:0] PCM_JALR = 2'b10;
  localparam logic [1:0] PCM_BR   = 2'b11;

  localparam logic [2:0] OFF_NONE = 3'b000;
  localparam logic [2:0] OFF_B    = 3'b001;
  localparam logic [2:0] OFF_H    = 3'b010;
  localparam logic [2:0] OFF_W    = 3'b100;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct3 to datapath-field table with illegal detection
// and the path class the FSM uses to sequence the instruction.
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [2:0] mem_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [2:0] mem_offset,
  output logic       unsigned_flag,
  output logic [1:0] pc_mux,
  output logic       illegal,
  output path_t      path
);

  // Field table lookup.
  always_comb begin
    mem_to_reg    = M2R_ALU;
    alu_src       = 1'b0;
    alu_op        = ALUOP_ADD;
    mem_offset    = OFF_NONE;
    unsigned_flag = 1'b0;
    pc_mux        = PCM_SEQ;
    illegal       = 1'b0;
    path          = P_NONE;
    case (opcode)
      OP_LUI: begin
        mem_to_reg = M2R_IMM;
        path       = P_WB;
      end
      OP_AUIPC: begin
        mem_to_reg = M2R_AUIPC;
        path       = P_WB;
      end
      OP_JAL: begin
        mem_to_reg = M2R_PC4;
        pc_mux     = PCM_JAL;
        path       = P_WB;
      end
      OP_JALR: begin
        mem_to_reg = M2R_PC4;
        alu_src    = 1'b1;
        pc_mux     = PCM_JALR;
        path       = P_WB;
      end
      OP_BRANCH: begin
        alu_op = ALUOP_BR;
        pc_mux = PCM_BR;
        path   = P_BRANCH;
      end
      OP_IMM: begin
        alu_src = 1'b1;
        alu_op  = ALUOP_IMM;
        path    = P_WB;
      end
      OP_REG: begin
        alu_op = ALUOP_REG;
        path   = P_WB;
      end
      OP_LOAD: begin
        mem_to_reg = M2R_MEM;
        alu_src    = 1'b1;
        path       = P_LOAD;
        case (funct3)
          3'b000:  mem_offset = OFF_B;
          3'b001:  mem_offset = OFF_H;
          3'b010:  mem_offset = OFF_W;
          3'b100: begin
            mem_offset    = OFF_B;
            unsigned_flag = 1'b1;
          end
          3'b101: begin
            mem_offset    = OFF_H;
            unsigned_flag = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            path    = P_NONE;
          end
        endcase
      end
      OP_STORE: begin
        alu_src = 1'b1;
        path    = P_STORE;
        case (funct3)
          3'b000:  mem_offset = OFF_B;
          3'b001:  mem_offset = OFF_H;
          3'b010:  mem_offset = OFF_W;
          default: begin
            illegal = 1'b1;
            path    = P_NONE;
          end
        endcase
      end
      OP_FENCE:  path = P_NOP;
      OP_SYSTEM: path = P_SYS;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM sequencing FETCH/DECODE/EXEC/MEM/WB over one shared,
// variable-latency memory port, with sticky halt, illegal and bus-error states.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int ENABLE_HALT = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] inst,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_is_fetch,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic [2:0] memToReg,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic [2:0] memOffset,
  output logic       unsignedFlag,
  output logic [1:0] PC_mux,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_o
);

  state_t          state_r, state_s;
  logic [6:0]      op_r;
  logic [2:0]      f3_r;
  logic [TO_W-1:0] to_r;
  logic            illegal_r, bus_err_r;

  logic [6:0] dec_op_s;
  logic [2:0] dec_f3_s;
  logic [2:0] dec_m2r_s, dec_off_s;
  logic       dec_src_s, dec_uns_s, dec_ill_s;
  logic [1:0] dec_aluop_s, dec_pcm_s;
  path_t      dec_path_s;

  logic waiting_s, to_expire_s, fields_on_s;
  logic mem_req_s, is_fetch_s, ir_write_s, pc_write_s, branch_s;
  logic mem_read_s, mem_write_s, reg_write_s;

  // DECODE looks at the live IR fields; later states use the copy latched there.
  assign dec_op_s = (state_r == S_DECODE) ? inst   : op_r;
  assign dec_f3_s = (state_r == S_DECODE) ? funct3 : f3_r;

  ctrl_decode u_decode (
    .opcode        (dec_op_s),
    .funct3        (dec_f3_s),
    .mem_to_reg    (dec_m2r_s),
    .alu_src       (dec_src_s),
    .alu_op        (dec_aluop_s),
    .mem_offset    (dec_off_s),
    .unsigned_flag (dec_uns_s),
    .pc_mux        (dec_pcm_s),
    .illegal       (dec_ill_s),
    .path          (dec_path_s)
  );

  assign waiting_s   = (state_r == S_FETCH) || (state_r == S_MEM);
  assign to_expire_s = (MEM_TIMEOUT != 0) && !mem_ready &&
                       (to_r == TO_W'(MEM_TIMEOUT - 1));
  assign fields_on_s = (state_r == S_EXEC) || (state_r == S_MEM) || (state_r == S_WB);

  // State, latched IR fields, timeout counter and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_FETCH;
      op_r      <= 7'd0;
      f3_r      <= 3'd0;
      to_r      <= '0;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == S_DECODE) begin
        op_r <= inst;
        f3_r <= funct3;
      end
      if (waiting_s && !mem_ready && (state_s == state_r)) begin
        to_r <= to_r + TO_W'(1);
      end else begin
        to_r <= '0;
      end
      if ((state_r == S_DECODE) && dec_ill_s) begin
        illegal_r <= 1'b1;
      end
      if (waiting_s && to_expire_s) begin
        bus_err_r <= 1'b1;
      end
    end
  end

  // Next-state and strobe generation.
  always_comb begin
    state_s     = state_r;
    mem_req_s   = 1'b0;
    is_fetch_s  = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    branch_s    = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        is_fetch_s = 1'b1;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          state_s    = S_DECODE;
        end else if (to_expire_s) begin
          state_s = S_TRAP;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_ill_s) begin
          state_s = S_TRAP;
        end else if ((dec_path_s == P_SYS) && (ENABLE_HALT != 0)) begin
          state_s = S_HALT;
        end else begin
          state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        case (dec_path_s)
          P_LOAD, P_STORE: state_s = S_MEM;
          P_WB:            state_s = S_WB;
          P_BRANCH: begin
            branch_s   = 1'b1;
            pc_write_s = 1'b1;
            state_s    = S_FETCH;
          end
          default: begin
            pc_write_s = 1'b1;
            state_s    = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req_s   = 1'b1;
        mem_read_s  = (dec_path_s == P_LOAD);
        mem_write_s = (dec_path_s == P_STORE);
        if (mem_ready) begin
          if (dec_path_s == P_LOAD) begin
            state_s = S_WB;
          end else begin
            pc_write_s = 1'b1;
            state_s    = S_FETCH;
          end
        end else if (to_expire_s) begin
          state_s = S_TRAP;
        end else begin
          state_s = S_MEM;
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        state_s     = S_FETCH;
      end
      S_HALT:  state_s = S_HALT;
      S_TRAP:  state_s = S_TRAP;
      default: state_s = S_TRAP;
    endcase
  end

  // Reset forces every output low at once, even though the state already reads FETCH.
  always_comb begin
    if (rst) begin
      mem_req      = 1'b0;
      mem_is_fetch = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      branch       = 1'b0;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      regWrite     = 1'b0;
      memToReg     = 3'd0;
      ALUSrc       = 1'b0;
      ALUOp        = 2'd0;
      memOffset    = 3'd0;
      unsignedFlag = 1'b0;
      PC_mux       = 2'd0;
      halted       = 1'b0;
      illegal      = 1'b0;
      bus_err      = 1'b0;
      state_o      = 3'd0;
    end else begin
      mem_req      = mem_req_s;
      mem_is_fetch = is_fetch_s;
      ir_write     = ir_write_s;
      pc_write     = pc_write_s;
      branch       = branch_s;
      memRead      = mem_read_s;
      memWrite     = mem_write_s;
      regWrite     = reg_write_s;
      memToReg     = fields_on_s ? dec_m2r_s   : 3'd0;
      ALUSrc       = fields_on_s ? dec_src_s   : 1'b0;
      ALUOp        = fields_on_s ? dec_aluop_s : 2'd0;
      memOffset    = fields_on_s ? dec_off_s   : 3'd0;
      unsignedFlag = fields_on_s ? dec_uns_s   : 1'b0;
      PC_mux       = fields_on_s ? dec_pcm_s   : 2'd0;
      halted       = (state_r == S_HALT);
      illegal      = illegal_r;
      bus_err      = bus_err_r;
      state_o      = state_r;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: dut runs ENABLE_HALT=1 with MEM_TIMEOUT=4, dut0 runs ENABLE_HALT=0
// with the default timeout; both share clock and inputs.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] inst = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       mem_ready = 1'b0;

  logic       mem_req, mem_is_fetch, ir_write, pc_write, branch, memRead, memWrite, regWrite;
  logic [2:0] memToReg, memOffset, state_o;
  logic       ALUSrc, unsignedFlag, halted, illegal, bus_err;
  logic [1:0] ALUOp, PC_mux;

  logic       mem_req0, mem_is_fetch0, ir_write0, pc_write0, branch0, memRead0, memWrite0, regWrite0;
  logic [2:0] memToReg0, memOffset0, state_o0;
  logic       ALUSrc0, unsignedFlag0, halted0, illegal0, bus_err0;
  logic [1:0] ALUOp0, PC_mux0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ENABLE_HALT(1), .MEM_TIMEOUT(4), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .inst(inst), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_is_fetch(mem_is_fetch), .ir_write(ir_write), .pc_write(pc_write),
    .branch(branch), .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .memToReg(memToReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .memOffset(memOffset),
    .unsignedFlag(unsignedFlag), .PC_mux(PC_mux), .halted(halted), .illegal(illegal),
    .bus_err(bus_err), .state_o(state_o)
  );

  multicycle_control_unit #(.ENABLE_HALT(0), .MEM_TIMEOUT(16), .TO_W(5)) dut0 (
    .clk(clk), .rst(rst), .inst(inst), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req0), .mem_is_fetch(mem_is_fetch0), .ir_write(ir_write0), .pc_write(pc_write0),
    .branch(branch0), .memRead(memRead0), .memWrite(memWrite0), .regWrite(regWrite0),
    .memToReg(memToReg0), .ALUSrc(ALUSrc0), .ALUOp(ALUOp0), .memOffset(memOffset0),
    .unsignedFlag(unsignedFlag0), .PC_mux(PC_mux0), .halted(halted0), .illegal(illegal0),
    .bus_err(bus_err0), .state_o(state_o0)
  );

  // Output bundle: strobes[25:18] {mem_req,is_fetch,ir_write,pc_write,branch,memRead,memWrite,regWrite},
  // fields[17:6] {memToReg,ALUSrc,ALUOp,memOffset,unsignedFlag,PC_mux}, flags[5:3] {halted,illegal,bus_err}, state[2:0].
  logic [25:0] obus, obus0;
  assign obus  = {mem_req, mem_is_fetch, ir_write, pc_write, branch, memRead, memWrite, regWrite,
                  memToReg, ALUSrc, ALUOp, memOffset, unsignedFlag, PC_mux,
                  halted, illegal, bus_err, state_o};
  assign obus0 = {mem_req0, mem_is_fetch0, ir_write0, pc_write0, branch0, memRead0, memWrite0, regWrite0,
                  memToReg0, ALUSrc0, ALUOp0, memOffset0, unsignedFlag0, PC_mux0,
                  halted0, illegal0, bus_err0, state_o0};

  localparam logic [7:0]  ST_NONE  = 8'b00000000;
  localparam logic [7:0]  ST_FETCH = 8'b11000000;
  localparam logic [7:0]  ST_FIR   = 8'b11100000;
  localparam logic [11:0] FLD_NONE = 12'b000_0_00_000_0_00;

  // Leaves the bench at a falling edge with FETCH as the current state.
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (obus !== 26'd0) $display("FAIL reset_held got %b exp %b", obus, 26'd0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    total++;
    if (obus !== {ST_FETCH, FLD_NONE, 3'b000, 3'd0})
      $display("FAIL reset_release got %b exp %b", obus, {ST_FETCH, FLD_NONE, 3'b000, 3'd0});
    else passed++;
  endtask

  task automatic test_add();
    logic [25:0] exp_v [5];
    logic        rdy_v [5];
    exp_v[0] = {ST_FIR,       FLD_NONE,                3'b000, 3'd0}; rdy_v[0] = 1'b1;
    exp_v[1] = {ST_NONE,      FLD_NONE,                3'b000, 3'd1}; rdy_v[1] = 1'b1;
    exp_v[2] = {ST_NONE,      12'b000_0_10_000_0_00,   3'b000, 3'd2}; rdy_v[2] = 1'b1;
    exp_v[3] = {8'b00010001,  12'b000_0_10_000_0_00,   3'b000, 3'd4}; rdy_v[3] = 1'b1;
    exp_v[4] = {ST_FETCH,     FLD_NONE,                3'b000, 3'd0}; rdy_v[4] = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      inst = (i < 2) ? 7'b0110011 : 7'b1111111;
      funct3 = 3'b000;
      mem_ready = rdy_v[i];
      #1;
      total++;
      if (obus !== exp_v[i]) $display("FAIL add_c%0d got %b exp %b", i, obus, exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_lbu_wait();
    logic [25:0] exp_v [9];
    logic        rdy_v [9];
    localparam logic [11:0] FLD_LBU = 12'b001_1_00_001_1_00;
    exp_v[0] = {ST_FIR,      FLD_NONE, 3'b000, 3'd0}; rdy_v[0] = 1'b1;
    exp_v[1] = {ST_NONE,     FLD_NONE, 3'b000, 3'd1}; rdy_v[1] = 1'b0;
    exp_v[2] = {ST_NONE,     FLD_LBU,  3'b000, 3'd2}; rdy_v[2] = 1'b0;
    exp_v[3] = {8'b10000100, FLD_LBU,  3'b000, 3'd3}; rdy_v[3] = 1'b0;
    exp_v[4] = {8'b10000100, FLD_LBU,  3'b000, 3'd3}; rdy_v[4] = 1'b0;
    exp_v[5] = {8'b10000100, FLD_LBU,  3'b000, 3'd3}; rdy_v[5] = 1'b0;
    exp_v[6] = {8'b10000100, FLD_LBU,  3'b000, 3'd3}; rdy_v[6] = 1'b1;
    exp_v[7] = {8'b00010001, FLD_LBU,  3'b000, 3'd4}; rdy_v[7] = 1'b0;
    exp_v[8] = {ST_FETCH,    FLD_NONE, 3'b000, 3'd0}; rdy_v[8] = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      inst   = (i < 2) ? 7'b0000011 : 7'b0110111;
      funct3 = (i < 2) ? 3'b100 : 3'b011;
      mem_ready = rdy_v[i];
      #1;
      total++;
      if (obus !== exp_v[i]) $display("FAIL lbu_c%0d got %b exp %b", i, obus, exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_illegal_store();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      inst = 7'b0100011;
      funct3 = 3'b011;
      mem_ready = (i == 0) || (i >= 4);
      #1;
      total++;
      if (i == 0) begin
        if (obus !== {ST_FIR, FLD_NONE, 3'b000, 3'd0})
          $display("FAIL ill_fetch got %b exp %b", obus, {ST_FIR, FLD_NONE, 3'b000, 3'd0});
        else passed++;
      end else if (i == 1) begin
        if (obus !== {ST_NONE, FLD_NONE, 3'b000, 3'd1})
          $display("FAIL ill_decode got %b exp %b", obus, {ST_NONE, FLD_NONE, 3'b000, 3'd1});
        else passed++;
      end else begin
        if (obus !== {ST_NONE, FLD_NONE, 3'b010, 3'd6})
          $display("FAIL ill_trap_c%0d got %b exp %b", i, obus, {ST_NONE, FLD_NONE, 3'b010, 3'd6});
        else passed++;
      end
    end
  endtask

  task automatic test_ecall();
    do_reset();
    inst = 7'b1110011;
    funct3 = 3'b000;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (obus !== {ST_NONE, FLD_NONE, 3'b000, 3'd1})
      $display("FAIL ecall_decode got %b exp %b", obus, {ST_NONE, FLD_NONE, 3'b000, 3'd1});
    else passed++;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if (obus0 !== {8'b00010000, FLD_NONE, 3'b000, 3'd2})
      $display("FAIL ecall_nohalt_exec got %b exp %b", obus0, {8'b00010000, FLD_NONE, 3'b000, 3'd2});
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (obus0 !== {ST_FETCH, FLD_NONE, 3'b000, 3'd0})
      $display("FAIL ecall_nohalt_fetch got %b exp %b", obus0, {ST_FETCH, FLD_NONE, 3'b000, 3'd0});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      total++;
      if (obus !== {ST_NONE, FLD_NONE, 3'b100, 3'd5})
        $display("FAIL ecall_halt_c%0d got %b exp %b", i, obus, {ST_NONE, FLD_NONE, 3'b100, 3'd5});
      else passed++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    inst = 7'b0110011;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = 1'b0;
      #1;
      total++;
      if (i < 4) begin
        if (obus !== {ST_FETCH, FLD_NONE, 3'b000, 3'd0})
          $display("FAIL to_wait_c%0d got %b exp %b", i, obus, {ST_FETCH, FLD_NONE, 3'b000, 3'd0});
        else passed++;
      end else begin
        if (obus !== {ST_NONE, FLD_NONE, 3'b001, 3'd6})
          $display("FAIL to_trap_c%0d got %b exp %b", i, obus, {ST_NONE, FLD_NONE, 3'b001, 3'd6});
        else passed++;
      end
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = (i == 3);
      #1;
      if (i == 3) begin
        total++;
        if (obus !== {ST_FIR, FLD_NONE, 3'b000, 3'd0})
          $display("FAIL to_lastcycle got %b exp %b", obus, {ST_FIR, FLD_NONE, 3'b000, 3'd0});
        else passed++;
      end else if (i == 4) begin
        total++;
        if (obus !== {ST_NONE, FLD_NONE, 3'b000, 3'd1})
          $display("FAIL to_decode got %b exp %b", obus, {ST_NONE, FLD_NONE, 3'b000, 3'd1});
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] exp_v [8];
    logic [6:0]  op_v  [8];
    exp_v[0] = {ST_FIR,      FLD_NONE,              3'b000, 3'd0}; op_v[0] = 7'b1100011;
    exp_v[1] = {ST_NONE,     FLD_NONE,              3'b000, 3'd1}; op_v[1] = 7'b1100011;
    exp_v[2] = {8'b00011000, 12'b000_0_11_000_0_11, 3'b000, 3'd2}; op_v[2] = 7'b0000000;
    exp_v[3] = {ST_FIR,      FLD_NONE,              3'b000, 3'd0}; op_v[3] = 7'b1101111;
    exp_v[4] = {ST_NONE,     FLD_NONE,              3'b000, 3'd1}; op_v[4] = 7'b1101111;
    exp_v[5] = {ST_NONE,     12'b010_0_00_000_0_01, 3'b000, 3'd2}; op_v[5] = 7'b0000000;
    exp_v[6] = {8'b00010001, 12'b010_0_00_000_0_01, 3'b000, 3'd4}; op_v[6] = 7'b0000000;
    exp_v[7] = {ST_FIR,      FLD_NONE,              3'b000, 3'd0}; op_v[7] = 7'b0000000;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      inst = op_v[i];
      funct3 = 3'b000;
      mem_ready = 1'b1;
      #1;
      total++;
      if (obus !== exp_v[i]) $display("FAIL b2b_c%0d got %b exp %b", i, obus, exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    inst = 7'b0100011;
    funct3 = 3'b010;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (obus !== {ST_NONE, 12'b000_1_00_100_0_00, 3'b000, 3'd2})
      $display("FAIL sw_exec got %b exp %b", obus, {ST_NONE, 12'b000_1_00_100_0_00, 3'b000, 3'd2});
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (obus !== {8'b10000010, 12'b000_1_00_100_0_00, 3'b000, 3'd3})
      $display("FAIL sw_mem got %b exp %b", obus, {8'b10000010, 12'b000_1_00_100_0_00, 3'b000, 3'd3});
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (obus !== 26'd0) $display("FAIL sw_async_rst got %b exp %b", obus, 26'd0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (obus !== {ST_FETCH, FLD_NONE, 3'b000, 3'd0})
      $display("FAIL sw_after_rst got %b exp %b", obus, {ST_FETCH, FLD_NONE, 3'b000, 3'd0});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lbu_wait();
    test_illegal_store();
    test_ecall();
    test_timeout();
    test_back_to_back();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
